midi_polyphony: RTL and testbench

- MIDI front end for the synth voice bank.
- Parses a byte stream from the UART receiver (DATA qualified by a DV strobe) for one selectable channel.
- Decodes Note On, Note Off and Program Change messages.
- Allocates notes to 4 voice slots, whose note number and velocity drive the per-voice oscillators and envelopes.

---
 rtl/midi_pkg.sv | 20 ++
 rtl/midi_polyphony_if.sv | 34 +++
 rtl/midi_parser.sv | 80 ++++++++
 rtl/midi_polyphony.sv | 91 +++++++++
 tb/tb_midi_polyphony.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants and types for the MIDI polyphony front end
// Contents: status nibble codes, realtime threshold, voice count, parser state enum.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG_CHG = 4'hC;

  // Status bytes at or above this value are realtime and never disturb parsing.
  localparam logic [7:0] RT_MIN = 8'hF8;

  localparam int VOICES = 4;

  typedef enum logic [1:0] {
    IDLE,   // no usable running status; data bytes are dropped
    DATA1,  // waiting for first data byte (note number or program)
    DATA2   // waiting for velocity byte
  } parse_state_t;

endpackage

// File: rtl/midi_polyphony_if.sv
// rtl/midi_polyphony_if.sv - byte-stream input and decoded/voice outputs of the MIDI front end
// master: drives CE, CHANNEL, DATA, DV and observes all outputs.
// slave : the midi_polyphony block; consumes the byte stream, drives note/program/slot outputs.
interface midi_polyphony_if;

  logic       CE;
  logic [3:0] CHANNEL;
  logic [7:0] DATA;
  logic       DV;

  logic [6:0] NOTE_NUM;
  logic [6:0] NOTE_VEL;
  logic [6:0] PROGRAM;
  logic       NOTE_ON_OUT;
  logic       NOTE_OFF_OUT;

  logic [6:0] NOTE_NUM_0, NOTE_NUM_1, NOTE_NUM_2, NOTE_NUM_3;
  logic [6:0] NOTE_VEL_0, NOTE_VEL_1, NOTE_VEL_2, NOTE_VEL_3;

  modport master (
    output CE, CHANNEL, DATA, DV,
    input  NOTE_NUM, NOTE_VEL, PROGRAM, NOTE_ON_OUT, NOTE_OFF_OUT,
    input  NOTE_NUM_0, NOTE_NUM_1, NOTE_NUM_2, NOTE_NUM_3,
    input  NOTE_VEL_0, NOTE_VEL_1, NOTE_VEL_2, NOTE_VEL_3
  );

  modport slave (
    input  CE, CHANNEL, DATA, DV,
    output NOTE_NUM, NOTE_VEL, PROGRAM, NOTE_ON_OUT, NOTE_OFF_OUT,
    output NOTE_NUM_0, NOTE_NUM_1, NOTE_NUM_2, NOTE_NUM_3,
    output NOTE_VEL_0, NOTE_VEL_1, NOTE_VEL_2, NOTE_VEL_3
  );

endinterface

// File: rtl/midi_parser.sv
// rtl/midi_parser.sv - MIDI byte-stream parser for Note On/Off and Program Change on one channel
// Inputs : clk, rst_n (async, active-low), ce, channel[3:0], data[7:0], dv.
// Outputs: note_num/note_vel (last note message), prog_num (last program),
//          note_on/note_off one-cycle pulses on message completion.
module midi_parser
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [3:0] channel,
  input  logic [7:0] data,
  input  logic       dv,
  output logic [6:0] note_num,
  output logic [6:0] note_vel,
  output logic [6:0] prog_num,
  output logic       note_on,
  output logic       note_off
);

  parse_state_t state;
  logic [3:0]   kind;    // running status high nibble
  logic [6:0]   data1;   // note number held until velocity arrives

  logic status_ok;
  assign status_ok = (data[3:0] == channel) &&
                     ((data[7:4] == NOTE_OFF) || (data[7:4] == NOTE_ON) ||
                      (data[7:4] == PROG_CHG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      kind     <= '0;
      data1    <= '0;
      note_num <= '0;
      note_vel <= '0;
      prog_num <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
    end else if (ce) begin
      // Pulses are cleared only on enabled cycles so the whole block freezes together with CE.
      note_on  <= 1'b0;
      note_off <= 1'b0;
      if (dv) begin
        if (data[7]) begin
          if (data < RT_MIN) begin
            if (status_ok) begin
              kind  <= data[7:4];
              state <= DATA1;
            end else begin
              state <= IDLE;
            end
          end
        end else begin
          case (state)
            IDLE: ;
            DATA1: begin
              if (kind == PROG_CHG) begin
                prog_num <= data[6:0];
              end else begin
                data1 <= data[6:0];
                state <= DATA2;
              end
            end
            DATA2: begin
              note_num <= data1;
              note_vel <= data[6:0];
              // Note On with zero velocity is a Note Off by MIDI convention.
              if (kind == NOTE_ON && data[6:0] != 7'd0) note_on <= 1'b1;
              else                                      note_off <= 1'b1;
              state <= DATA1;   // running status kept for the next pair
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/midi_polyphony.sv
// rtl/midi_polyphony.sv - MIDI front end with a 4-slot voice allocator
// Ports: CLK, RST (async, active-low) plus bus (midi_polyphony_if.slave) carrying the
//        byte stream in and the decoded note/program and per-slot note/velocity out.
module midi_polyphony
  import midi_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  midi_polyphony_if.slave   bus
);

  logic [6:0] note_num, note_vel, prog_num;
  logic       note_on, note_off;

  midi_parser u_parser (
    .clk      (CLK),
    .rst_n    (RST),
    .ce       (bus.CE),
    .channel  (bus.CHANNEL),
    .data     (bus.DATA),
    .dv       (bus.DV),
    .note_num (note_num),
    .note_vel (note_vel),
    .prog_num (prog_num),
    .note_on  (note_on),
    .note_off (note_off)
  );

  logic [6:0] slot_num [VOICES];
  logic [6:0] slot_vel [VOICES];

  // Lowest-index busy slot already holding the note, and lowest-index free slot.
  logic       hit, free;
  logic [1:0] hit_idx, free_idx;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free     = 1'b0;
    free_idx = 2'd0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (slot_vel[i] != 7'd0 && slot_num[i] == note_num) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (slot_vel[i] == 7'd0) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < VOICES; i++) begin
        slot_num[i] <= '0;
        slot_vel[i] <= '0;
      end
    end else if (bus.CE) begin
      if (note_on) begin
        if (hit) begin
          slot_vel[hit_idx] <= note_vel;
        end else if (free) begin
          slot_num[free_idx] <= note_num;
          slot_vel[free_idx] <= note_vel;
        end
      end else if (note_off) begin
        // Note number is kept so the envelope can run its release on the same pitch.
        for (int i = 0; i < VOICES; i++) begin
          if (slot_vel[i] != 7'd0 && slot_num[i] == note_num) slot_vel[i] <= '0;
        end
      end
    end
  end

  assign bus.NOTE_NUM     = note_num;
  assign bus.NOTE_VEL     = note_vel;
  assign bus.PROGRAM      = prog_num;
  assign bus.NOTE_ON_OUT  = note_on;
  assign bus.NOTE_OFF_OUT = note_off;

  assign bus.NOTE_NUM_0 = slot_num[0];
  assign bus.NOTE_NUM_1 = slot_num[1];
  assign bus.NOTE_NUM_2 = slot_num[2];
  assign bus.NOTE_NUM_3 = slot_num[3];
  assign bus.NOTE_VEL_0 = slot_vel[0];
  assign bus.NOTE_VEL_1 = slot_vel[1];
  assign bus.NOTE_VEL_2 = slot_vel[2];
  assign bus.NOTE_VEL_3 = slot_vel[3];

endmodule

// File: tb/tb_midi_polyphony.sv
// tb/tb_midi_polyphony.sv - scoreboard testbench for midi_polyphony
module tb_midi_polyphony;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  midi_polyphony_if bus ();

  midi_polyphony dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic            is_on;
    logic [6:0]      num;
    logic [6:0]      vel;
    logic [3:0][6:0] sn;
    logic [3:0][6:0] sv;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  exp_t       pend;
  logic       pend_v = 1'b0;
  logic [6:0] m_num [4];
  logic [6:0] m_vel [4];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         on_seen = 0;
  int         on_exp = 0;

  logic [6:0] dut_num [4];
  logic [6:0] dut_vel [4];
  assign dut_num[0] = bus.NOTE_NUM_0;
  assign dut_num[1] = bus.NOTE_NUM_1;
  assign dut_num[2] = bus.NOTE_NUM_2;
  assign dut_num[3] = bus.NOTE_NUM_3;
  assign dut_vel[0] = bus.NOTE_VEL_0;
  assign dut_vel[1] = bus.NOTE_VEL_1;
  assign dut_vel[2] = bus.NOTE_VEL_2;
  assign dut_vel[3] = bus.NOTE_VEL_3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: slot check one cycle after each pulse, then match any new pulse to the queue head.
  always @(negedge CLK) begin
    if (pend_v) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("slot%0d_num", i), dut_num[i], pend.sn[i]);
        check($sformatf("slot%0d_vel", i), dut_vel[i], pend.sv[i]);
      end
      pend_v = 1'b0;
    end
    if (RST && (bus.NOTE_ON_OUT || bus.NOTE_OFF_OUT)) begin
      if (bus.NOTE_ON_OUT) on_seen++;
      if (q.size() == 0) begin
        check("unexpected_pulse", {bus.NOTE_ON_OUT, bus.NOTE_OFF_OUT}, 2'b00);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", {bus.NOTE_ON_OUT, bus.NOTE_OFF_OUT}, mon_e.is_on ? 2'b10 : 2'b01);
        check("note_num", bus.NOTE_NUM, mon_e.num);
        check("note_vel", bus.NOTE_VEL, mon_e.vel);
        pend   = mon_e;
        pend_v = 1'b1;
      end
    end
  end

  // Reference allocator and expectation push for a completed note message.
  task automatic model_push(input logic [3:0] kind, input logic [6:0] num, input logic [6:0] vel);
    exp_t e;
    logic is_on;
    logic done;
    is_on = (kind == 4'h9) && (vel != 7'd0);
    done  = 1'b0;
    if (is_on) begin
      on_exp++;
      for (int i = 0; i < 4; i++)
        if (!done && m_vel[i] != 0 && m_num[i] == num) begin m_vel[i] = vel; done = 1'b1; end
      for (int i = 0; i < 4; i++)
        if (!done && m_vel[i] == 0) begin m_num[i] = num; m_vel[i] = vel; done = 1'b1; end
    end else begin
      for (int i = 0; i < 4; i++)
        if (m_vel[i] != 0 && m_num[i] == num) m_vel[i] = 7'd0;
    end
    e.is_on = is_on;
    e.num   = num;
    e.vel   = vel;
    for (int i = 0; i < 4; i++) begin
      e.sn[i] = m_num[i];
      e.sv[i] = m_vel[i];
    end
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.DATA = b;
    bus.DV   = 1'b1;
    @(negedge CLK);
    bus.DV   = 1'b0;
  endtask

  task automatic send_pair(input logic [3:0] kind, input logic [6:0] num, input logic [6:0] vel);
    send_byte({1'b0, num});
    model_push(kind, num, vel);
    send_byte({1'b0, vel});
  endtask

  task automatic send_note(input logic [7:0] st, input logic [6:0] num, input logic [6:0] vel);
    send_byte(st);
    send_pair(st[7:4], num, vel);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && (q.size() != 0 || pend_v); k++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_num"},  bus.NOTE_NUM, 0);
    check({tag, "_vel"},  bus.NOTE_VEL, 0);
    check({tag, "_prog"}, bus.PROGRAM, 0);
    check({tag, "_pulses"}, {bus.NOTE_ON_OUT, bus.NOTE_OFF_OUT}, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_s%0dn", tag, i), dut_num[i], 0);
      check($sformatf("%s_s%0dv", tag, i), dut_vel[i], 0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_num[i] = '0;
      m_vel[i] = '0;
    end
  endtask

  initial begin
    bus.CE      = 1'b1;
    bus.CHANNEL = 4'd0;
    bus.DATA    = 8'd0;
    bus.DV      = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Fill all four slots, then a fifth note is dropped but still pulses.
    for (int n = 10; n <= 13; n++) send_note(8'h90, 7'(n), 7'd127);
    send_note(8'h90, 7'd15, 7'd127);
    wait_drain();

    // Off on slot 0 keeps its note number, then a new note reuses the slot.
    send_note(8'h80, 7'd10, 7'd127);
    send_note(8'h90, 7'd14, 7'd127);
    // Off via Note Off with velocity 0, then running-status on/off pair.
    send_note(8'h80, 7'd11, 7'd0);
    send_note(8'h90, 7'd20, 7'd100);
    send_pair(4'h9, 7'd20, 7'd0);
    // Repeated note already sounding only updates its velocity.
    send_note(8'h90, 7'd12, 7'd50);
    wait_drain();

    // Wrong channel: nothing decoded.
    send_byte(8'h91); send_byte(8'd30); send_byte(8'd90);
    // Program change with running status; wrong channel program ignored.
    send_byte(8'hC0); send_byte(8'd5);
    @(negedge CLK);
    check("program_5", bus.PROGRAM, 5);
    send_byte(8'd7);
    @(negedge CLK);
    check("program_rs_7", bus.PROGRAM, 7);
    send_byte(8'hC1); send_byte(8'd9);
    @(negedge CLK);
    check("program_other_ch", bus.PROGRAM, 7);
    // Unsupported status clears running status.
    send_byte(8'h90); send_byte(8'hB0); send_byte(8'd23); send_byte(8'd40);
    wait_drain();

    // Realtime bytes interleaved inside a message.
    send_byte(8'h90); send_byte(8'hF8);
    send_byte(8'd21); send_byte(8'hFF);
    model_push(4'h9, 7'd21, 7'd60);
    send_byte(8'd60);
    // Free slot 3, then CE low mid-message holds the partial message.
    send_note(8'h80, 7'd13, 7'd64);
    send_byte(8'h90);
    bus.CE = 1'b0;
    send_byte(8'd99);
    send_byte(8'h80);
    bus.CE = 1'b1;
    send_pair(4'h9, 7'd22, 7'd70);
    // Another channel selection.
    bus.CHANNEL = 4'd3;
    send_note(8'h93, 7'd25, 7'd45);
    wait_drain();

    // Reset mid-message discards the partial message and clears running status.
    send_byte(8'h93); send_byte(8'd40);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    model_reset();
    check_zero("mid_reset");
    @(negedge CLK);
    RST = 1'b1;
    send_byte(8'd50); send_byte(8'd60);
    wait_drain();
    check("post_reset_s0v", dut_vel[0], 0);
    send_note(8'h93, 7'd41, 7'd33);
    wait_drain();

    check("on_pulse_count", on_seen, on_exp);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
